syn_wm8731_cfg_seq: RTL
=======================

// Module: syn_wm8731_cfg_seq
// PURPOSE
//  Configuration sequencer for the WM8731 audio codec control port. After reset it walks a
//  constant init table of register writes through the I2C master, then arbitrates host register
//  writes onto the same master. WM8731 registers are write-only, so it keeps a readable shadow copy.
//  Sits between the audio-block register map and the I2C master driving scl/sda.
// PARAMETERS
//  I2C_DEV_ADDR  7'h1A  7-bit WM8731 device address (CSB=0); write-only, R/W bit always 0
//  NUM_INIT      10     entries in init table (package constant WM8731_INIT_TABLE)
//  MAX_RETRY     3      total attempts per write on NACK before giving up on that entry
//  GAP_CYCLES    16     idle sys_clk cycles inserted after every transfer, incl. NACKed ones
// PORTS
//  sys_clk        in   1   system clock
//  sys_rst        in   1   synchronous reset, active-high
//  cfg_restart    in   1   re-run init table (sampled in READY only)
//  host_wr_req    in   1   host write request, held until host_wr_ack
//  host_wr_addr   in   7   WM8731 register address
//  host_wr_data   in   9   WM8731 register data
//  host_wr_ack    out  1   1-cycle pulse: request accepted, inputs latched
//  host_wr_done   out  1   1-cycle pulse: host write finished (ok, error or rejected)
//  host_wr_err    out  1   qualifies host_wr_done: illegal address or retries exhausted
//  shadow_rd_addr in   4   shadow register read address
//  shadow_rd_data out  9   shadow register value, 1-cycle latency
//  init_done      out  1   high in READY after init table completed
//  cfg_err        sticky   out 1; any init entry exhausted MAX_RETRY
//  i2c_start      out  1   1-cycle pulse to I2C master
//  i2c_dev_addr   out  7   = I2C_DEV_ADDR
//  i2c_wdata      out  16  {reg_addr[6:0], reg_data[8:0]}, MSB first on the bus
//  i2c_busy       in   1   master busy
//  i2c_done       in   1   1-cycle pulse: transfer finished
//  i2c_nack       in   1   valid with i2c_done: slave NACKed any byte
// BEHAVIOUR
//  Reset: all outputs 0; shadow loaded with WM8731_POR_DEFAULTS; idx=0; retry=0; state IDLE.
//   sys_rst mid-transfer aborts at once: i2c_start low, no done pulse.
//  FSM: IDLE -> LOAD (first cycle after reset release) -> ISSUE -> WAIT -> GAP -> LOAD|READY.
//   LOAD: latch next entry (init table entry idx, or the latched host request) into i2c_wdata.
//   ISSUE: wait for i2c_busy==0, then pulse i2c_start. i2c_wdata holds stable until WAIT exits.
//   WAIT: act on i2c_done only.
//    - nack=0: write the shadow. Address 7'h0F (reset reg) reloads all shadow entries to POR
//      defaults instead. Clear retry, go to GAP.
//    - nack=1 and retry<MAX_RETRY-1: retry++, GAP, then ISSUE with the same word.
//    - nack=1 and retry==MAX_RETRY-1: drop the entry. During init set cfg_err; for a host
//      write set err. Go to GAP.
//   GAP: count GAP_CYCLES. During init: idx++; after idx==NUM_INIT-1 go to READY with init_done=1.
//    During a host write: pulse host_wr_done/err at GAP end, then go to READY.
//   READY: cfg_restart has priority over a simultaneous host_wr_req. On restart: clear init_done
//    and cfg_err, idx=0, go to LOAD. On host_wr_req: ack pulse, latch addr/data, go to LOAD.
//  Host requests outside READY are not acked (the requester holds them). Init always runs first.
//  Illegal address (addr 10..14 or >15): ack, then host_wr_done+host_wr_err on the next cycle.
//   No I2C transfer, shadow unchanged.
//  i2c_done outside WAIT is ignored. i2c_nack is ignored without i2c_done.
//  Shadow read: addr 0..9 return the entry; 15 and illegal addresses return 9'h0. Registered.
//  Counters: idx $clog2(NUM_INIT); gap $clog2(GAP_CYCLES+1); retry $clog2(MAX_RETRY).
// STRUCTURE
//  syn_aud_codec_pkg holds:
//   - wm8731_wr_t struct {addr[6:0], data[8:0]}
//   - register address localparams (LINVOL..ACTIVE, RESET=7'h0F)
//   - WM8731_POR_DEFAULTS[10]
//   - WM8731_INIT_TABLE[NUM_INIT]; entry 0 is always RESET
//   - FSM state enum
//  Sub-module syn_wm8731_shadow_rf: 10x9 shadow, write port, POR reload strobe, registered read.
// TESTING
//  1. Reset, I2C model ACKs all. Expect 10 i2c_start pulses, first i2c_wdata=16'h1E00 (reg 0x0F).
//     Expect >=16 idle cycles between done and next start, then init_done=1, cfg_err=0.
//  2. Model NACKs the entry-2 write twice, then ACKs. Expect 3 starts with identical wdata,
//     cfg_err=0, init completes.
//  3. Model NACKs the entry-3 write 3 times. Expect cfg_err=1, entry skipped, remaining entries
//     sent, init_done=1, shadow[entry-3 addr] unchanged.
//  4. In READY, host writes addr 7'h04 data 9'h012. Expect ack, then wdata=16'h0812,
//     host_wr_done err=0, and shadow_rd_addr=4 returns 9'h012 next cycle.
//  5. Host writes addr 7'h0C. Expect ack, then done+err, no i2c_start. Host write addr 7'h0F:
//     all shadow entries return POR defaults.
//  6. Assert host_wr_req and cfg_restart together in READY. Expect restart taken, init rerun,
//     then host ack. Then assert sys_rst mid-WAIT: outputs zero, init restarts after release.

Source files
------------

// File: rtl/syn_aud_codec_pkg.sv
// Shared WM8731 definitions: write-word layout, register map, power-on
// defaults, the boot-time init table and the config sequencer states.
package syn_aud_codec_pkg;

  localparam int WM8731_NUM_REGS = 10;
  localparam int WM8731_NUM_INIT = 10;

  // One control-port write: 7-bit register address, 9-bit register data.
  // Packed so the struct is exactly the 16-bit word shifted out MSB first.
  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } wm8731_wr_t;

  localparam logic [6:0] WM_LINVOL   = 7'h00;
  localparam logic [6:0] WM_RINVOL   = 7'h01;
  localparam logic [6:0] WM_LHPOUT   = 7'h02;
  localparam logic [6:0] WM_RHPOUT   = 7'h03;
  localparam logic [6:0] WM_APANA    = 7'h04;
  localparam logic [6:0] WM_DAPATH   = 7'h05;
  localparam logic [6:0] WM_PWR      = 7'h06;
  localparam logic [6:0] WM_IFACE    = 7'h07;
  localparam logic [6:0] WM_SAMPLING = 7'h08;
  localparam logic [6:0] WM_ACTIVE   = 7'h09;
  localparam logic [6:0] WM_RESET    = 7'h0F;

  // Codec power-on values; index 0 is the rightmost element.
  localparam logic [WM8731_NUM_REGS-1:0][8:0] WM8731_POR_DEFAULTS = {
    9'h000,   // 9 ACTIVE
    9'h000,   // 8 SAMPLING
    9'h00A,   // 7 IFACE
    9'h09F,   // 6 PWR
    9'h008,   // 5 DAPATH
    9'h00A,   // 4 APANA
    9'h079,   // 3 RHPOUT
    9'h079,   // 2 LHPOUT
    9'h097,   // 1 RINVOL
    9'h097    // 0 LINVOL
  };

  // Boot sequence; entry 0 must be RESET so the codec and the shadow agree.
  localparam wm8731_wr_t [WM8731_NUM_INIT-1:0] WM8731_INIT_TABLE = {
    {WM_ACTIVE, 9'h001},  // 9 activate interface last
    {WM_IFACE,  9'h042},  // 8 I2S, 16-bit, master
    {WM_PWR,    9'h002},  // 7 power up all but mic
    {WM_DAPATH, 9'h000},  // 6 unmute DAC
    {WM_APANA,  9'h010},  // 5 DAC to output
    {WM_RHPOUT, 9'h079},  // 4
    {WM_LHPOUT, 9'h06F},  // 3
    {WM_RINVOL, 9'h017},  // 2
    {WM_LINVOL, 9'h017},  // 1
    {WM_RESET,  9'h000}   // 0
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_READY
  } cfg_state_t;

  // Registers 0..9 exist; 0x0F is the write-only reset register.
  function automatic logic reg_addr_legal(input logic [6:0] addr);
    return (addr < 7'd10) || (addr == WM_RESET);
  endfunction

endpackage

// File: rtl/syn_wm8731_shadow_rf.sv
// Readable shadow of the write-only WM8731 registers. A reload strobe
// restores every entry to its power-on value (mirrors a codec reset write).
module syn_wm8731_shadow_rf
  import syn_aud_codec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [8:0] wr_data,
  input  logic       reload,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data
);

  logic [8:0] mem [WM8731_NUM_REGS];

  // Storage: POR values on reset or reload, otherwise single-entry write.
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      for (int i = 0; i < WM8731_NUM_REGS; i++) begin
        mem[i] <= WM8731_POR_DEFAULTS[i];
      end
    end else if (wr_en && (wr_addr < 4'd10)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; the reset register and unmapped addresses read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 9'h000;
    end else if (rd_addr < 4'd10) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= 9'h000;
    end
  end

endmodule

// File: rtl/syn_wm8731_cfg_seq.sv
// WM8731 configuration sequencer: plays the init table through the I2C
// master after reset, then serialises host register writes onto the same
// master with retry-on-NACK and a fixed idle gap after every transfer.
module syn_wm8731_cfg_seq
  import syn_aud_codec_pkg::*;
#(
  parameter logic [6:0] I2C_DEV_ADDR = 7'h1A,
  parameter int         NUM_INIT     = WM8731_NUM_INIT,
  parameter int         MAX_RETRY    = 3,
  parameter int         GAP_CYCLES   = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cfg_restart,
  input  logic        host_wr_req,
  input  logic [6:0]  host_wr_addr,
  input  logic [8:0]  host_wr_data,
  output logic        host_wr_ack,
  output logic        host_wr_done,
  output logic        host_wr_err,
  input  logic [3:0]  shadow_rd_addr,
  output logic [8:0]  shadow_rd_data,
  output logic        init_done,
  output logic        cfg_err,
  output logic        i2c_start,
  output logic [6:0]  i2c_dev_addr,
  output logic [15:0] i2c_wdata,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_nack
);

  localparam int IDX_W = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int RTY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);

  cfg_state_t       state;
  cfg_state_t       state_nxt;
  logic [IDX_W-1:0] idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [RTY_W-1:0] retry;
  logic             retry_pend;
  logic             host_mode;
  logic             host_err;
  logic             init_cmpl;
  wm8731_wr_t       host_req;
  wm8731_wr_t       wdata;
  logic             host_legal;
  logic             gap_end;
  logic             shadow_wr_en;
  logic             shadow_reload;

  assign host_legal = reg_addr_legal(host_req.addr);
  assign gap_end    = (state == ST_GAP) && (gap_cnt == GAP_LAST);
  assign i2c_wdata  = wdata;

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = (host_mode && !host_legal) ? ST_READY : ST_ISSUE;
      ST_ISSUE: if (!i2c_busy) state_nxt = ST_WAIT;
      ST_WAIT:  if (i2c_done) state_nxt = ST_GAP;
      ST_GAP: begin
        if (gap_end) begin
          if (retry_pend) begin
            state_nxt = ST_ISSUE;
          end else if (host_mode || (idx == LAST_IDX)) begin
            state_nxt = ST_READY;
          end else begin
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_READY: if (cfg_restart || host_wr_req) state_nxt = ST_LOAD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs and shadow strobes decoded from the current state.
  always_comb begin
    i2c_start     = (state == ST_ISSUE) && !i2c_busy;
    i2c_dev_addr  = (state == ST_IDLE) ? 7'h00 : I2C_DEV_ADDR;
    host_wr_ack   = (state == ST_READY) && !cfg_restart && host_wr_req;
    host_wr_done  = 1'b0;
    host_wr_err   = 1'b0;
    if ((state == ST_LOAD) && host_mode && !host_legal) begin
      host_wr_done = 1'b1;
      host_wr_err  = 1'b1;
    end else if (gap_end && !retry_pend && host_mode) begin
      host_wr_done = 1'b1;
      host_wr_err  = host_err;
    end
    init_done     = init_cmpl && (state == ST_READY);
    shadow_wr_en  = (state == ST_WAIT) && i2c_done && !i2c_nack && (wdata.addr != WM_RESET);
    shadow_reload = (state == ST_WAIT) && i2c_done && !i2c_nack && (wdata.addr == WM_RESET);
  end

  // Sequencing registers: table index, retry/gap counters, host latch, flags.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idx        <= '0;
      gap_cnt    <= '0;
      retry      <= '0;
      retry_pend <= 1'b0;
      host_mode  <= 1'b0;
      host_err   <= 1'b0;
      init_cmpl  <= 1'b0;
      cfg_err    <= 1'b0;
      host_req   <= '0;
      wdata      <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          retry      <= '0;
          retry_pend <= 1'b0;
          if (!host_mode) begin
            wdata <= WM8731_INIT_TABLE[idx];
          end else if (host_legal) begin
            wdata <= host_req;
          end
        end
        ST_WAIT: begin
          if (i2c_done) begin
            gap_cnt <= '0;
            if (!i2c_nack) begin
              retry      <= '0;
              retry_pend <= 1'b0;
            end else if (retry < RTY_LAST) begin
              retry      <= retry + 1'b1;
              retry_pend <= 1'b1;
            end else begin
              retry      <= '0;
              retry_pend <= 1'b0;
              if (host_mode) begin
                host_err <= 1'b1;
              end else begin
                cfg_err  <= 1'b1;
              end
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_end && !retry_pend && !host_mode) begin
            if (idx == LAST_IDX) begin
              init_cmpl <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_READY: begin
          if (cfg_restart) begin
            init_cmpl <= 1'b0;
            cfg_err   <= 1'b0;
            idx       <= '0;
            host_mode <= 1'b0;
          end else if (host_wr_req) begin
            host_mode <= 1'b1;
            host_err  <= 1'b0;
            host_req  <= {host_wr_addr, host_wr_data};
          end
        end
        default: ;
      endcase
    end
  end

  syn_wm8731_shadow_rf u_shadow (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .wr_en   (shadow_wr_en),
    .wr_addr (wdata.addr[3:0]),
    .wr_data (wdata.data),
    .reload  (shadow_reload),
    .rd_addr (shadow_rd_addr),
    .rd_data (shadow_rd_data)
  );

endmodule
